// File: rtl/seg_red_unit_if.sv
// rtl/seg_red_unit_if.sv - beat/result bundle between the PE multiplier row, seg_red_unit and the output buffer
interface seg_red_unit_if #(
   parameter int N = 16,
   parameter int W = 8
);
   localparam int LGN = $clog2(N);

   logic                    in_valid;
   logic                    in_acc;
   logic [N-1:0][W-1:0]     data;
   logic [N-1:0]            split;
   logic [N-1:0][LGN-1:0]   out_idx;
   logic                    out_valid;
   logic [N-1:0][W-1:0]     out_data;
   int                      delay;
   int                      num_el;

   modport master (
      output in_valid, in_acc, data, split, out_idx,
      input  out_valid, out_data, delay, num_el
   );

   modport slave (
      input  in_valid, in_acc, data, split, out_idx,
      output out_valid, out_data, delay, num_el
   );
endinterface

// File: rtl/seg_red_unit.sv
// rtl/seg_red_unit.sv - pipelined segmented inclusive prefix-sum reducer with lane routing and output accumulation
module seg_red_unit #(
   parameter int N = 16,
   parameter int W = 8
) (
   input  logic           clock,
   input  logic           reset,
   seg_red_unit_if.slave  bus
);
   localparam int LGN = $clog2(N);

   typedef logic [N-1:0][W-1:0]   vec_t;
   typedef logic [N-1:0][LGN-1:0] idx_t;

   vec_t           r_v   [LGN];
   logic [N-1:0]   r_f   [LGN];
   idx_t           r_idx [LGN];
   logic [LGN-1:0] r_acc;
   logic [LGN-1:0] r_vld;
   vec_t           r_out;
   logic           r_out_valid;

   vec_t           w_sv  [LGN];
   logic [N-1:0]   w_sf  [LGN];
   vec_t           w_nv  [LGN];
   logic [N-1:0]   w_nf  [LGN];
   vec_t           w_sel;

   // A set flag marks a lane whose running sum already reaches its segment start.
   always_comb begin
      w_sv[0] = bus.data;
      w_sf[0] = {bus.split[N-2:0], 1'b1};
      for (int k = 1; k < LGN; k++) begin
         w_sv[k] = r_v[k-1];
         w_sf[k] = r_f[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < LGN; k++) begin
         w_nv[k] = w_sv[k];
         w_nf[k] = w_sf[k];
         for (int i = 0; i < N; i++) begin
            if ((i >= (1 << k)) && !w_sf[k][i]) begin
               w_nv[k][i] = w_sv[k][i] + w_sv[k][i - (1 << k)];
               w_nf[k][i] = w_sf[k][i] | w_sf[k][i - (1 << k)];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      r_idx[0] <= bus.out_idx;
      r_acc[0] <= bus.in_acc;
      for (int k = 0; k < LGN; k++) begin
         r_v[k] <= w_nv[k];
         r_f[k] <= w_nf[k];
      end
      for (int k = 1; k < LGN; k++) begin
         r_idx[k] <= r_idx[k-1];
         r_acc[k] <= r_acc[k-1];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= bus.in_valid;
         for (int k = 1; k < LGN; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
      end
   end

   always_comb begin
      w_sel = '0;
      for (int k = 0; k < N; k++) begin
         w_sel[k] = r_v[LGN-1][r_idx[LGN-1][k]];
      end
   end

   // Accumulation reads r_out as held at this edge, so back-to-back beats chain exactly.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else begin
         r_out_valid <= r_vld[LGN-1];
         if (r_vld[LGN-1]) begin
            for (int k = 0; k < N; k++) begin
               r_out[k] <= r_acc[LGN-1] ? (r_out[k] + w_sel[k]) : w_sel[k];
            end
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out;
   assign bus.delay     = LGN + 1;
   assign bus.num_el    = N;
endmodule
